// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two requesters, each with a private 2-entry FIFO, share the
// single register-file write port under round-robin arbitration.
module regfile_wb_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [4:0]  req0_addr_i,
    input  logic [63:0] req0_data_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [4:0]  req1_addr_i,
    input  logic [63:0] req1_data_i,
    output logic        wr_en_o,
    output logic [4:0]  wr_addr_o,
    output logic [63:0] wr_data_o,
    output logic [31:0] pending_o,
    output logic        idle_o
);

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 64;
    localparam int unsigned NREG  = 32;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    wb_entry_t        mem    [NREQ][DEPTH];
    logic [DEPTH-1:0] vld    [NREQ];
    logic             rd_ptr [NREQ];
    logic             wr_ptr [NREQ];
    logic             last_gnt;

    wb_entry_t        in_ent [NREQ];
    logic [NREQ-1:0]  in_vld;
    logic [NREQ-1:0]  ready;
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  head_vld;
    logic [NREQ-1:0]  gnt;
    wb_entry_t        head;

    // Request gathering, occupancy-only ready, round-robin grant
    always_comb begin
        in_vld[0] = req0_valid_i;
        in_vld[1] = req1_valid_i;
        in_ent[0] = {req0_addr_i, req0_data_i};
        in_ent[1] = {req1_addr_i, req1_data_i};
        for (int unsigned r = 0; r < NREQ; r++) begin
            ready[r]    = ~&vld[r];
            push[r]     = in_vld[r] & ready[r];
            head_vld[r] = vld[r][rd_ptr[r]];
        end
        gnt[0] = head_vld[0] & (~head_vld[1] | last_gnt);
        gnt[1] = head_vld[1] & ~gnt[0];
        head   = gnt[1] ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
    end

    assign req0_ready_o = ready[0];
    assign req1_ready_o = ready[1];

    // FIFO storage is data-path only; validity lives in vld
    always_ff @(posedge clk_i) begin
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (push[r]) begin
                mem[r][wr_ptr[r]] <= in_ent[r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                vld[r]    <= '0;
                rd_ptr[r] <= 1'b0;
                wr_ptr[r] <= 1'b0;
            end
            last_gnt  <= 1'b1;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            // Push and pop never target the same slot: push needs a free slot
            for (int unsigned r = 0; r < NREQ; r++) begin
                if (push[r]) begin
                    vld[r][wr_ptr[r]] <= 1'b1;
                    wr_ptr[r]         <= ~wr_ptr[r];
                end
                if (gnt[r]) begin
                    vld[r][rd_ptr[r]] <= 1'b0;
                    rd_ptr[r]         <= ~rd_ptr[r];
                end
            end
            if (|gnt) begin
                last_gnt  <= gnt[1];
                wr_en_o   <= (head.addr != AW'(0));
                wr_addr_o <= head.addr;
                wr_data_o <= head.data;
            end else begin
                wr_en_o   <= 1'b0;
            end
        end
    end

    // Scoreboard view for hazard detection; x0 is never reported
    always_comb begin
        pending_o = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld[r][i]) begin
                    pending_o[mem[r][i].addr] = 1'b1;
                end
            end
        end
        if (wr_en_o) begin
            pending_o[wr_addr_o] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

    assign idle_o = ~|vld[0] & ~|vld[1] & ~wr_en_o;

    localparam int unsigned UNUSED_NREG = NREG;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus hand-written
// sequences for latency, contention, backpressure, x0 drop and mid-stream reset.
module tb_regfile_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [4:0]  req0_addr_i, req1_addr_i;
    logic [63:0] req0_data_i, req1_data_i;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [63:0] wr_data_o;
    logic [31:0] pending_o;
    logic        idle_o;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .pending_o    (pending_o),
        .idle_o       (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [31:0] pend;
        logic        rdy0;
        logic        rdy1;
        logic        idle;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1);
        req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
        req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_0003;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_0004;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_0007;
    localparam logic [63:0] DD = 64'hDDDD_0000_0000_0008;

    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [4:0]  exp_addr [4];
    logic [63:0] exp_data [4];
    logic        seen_full1;
    logic [63:0] exp_d;

    initial begin
        // v0 a0 d0 v1 a1 d1 | en addr data pend rdy0 rdy1 idle
        vecs[0] = '{1'b1, 5'd3, DA, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0,   1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 5'd4, DB, 1'b1, 5'd7, DC,    1'b0, 5'd0, 64'd0, 32'h8,   1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd8, DD, 1'b1, 5'd3, DA,    32'h98,  1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, DC, 32'h190, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, DB, 32'h110, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd8, DD, 32'h100, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd8, DD, 32'h0,   1'b1, 1'b1, 1'b1};

        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        rst_i = 1'b0;
        #12;
        chk("reset wr_en", 64'(wr_en_o), 64'd0);
        chk("reset wr_addr", 64'(wr_addr_o), 64'd0);
        chk("reset wr_data", wr_data_o, 64'd0);
        chk("reset ready0", 64'(req0_ready_o), 64'd1);
        chk("reset ready1", 64'(req1_ready_o), 64'd1);
        chk("reset pending", 64'(pending_o), 64'd0);
        chk("reset idle", 64'(idle_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Vector table: outputs checked against state before the row's edge
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            chk($sformatf("vec%0d wr_en", i), 64'(wr_en_o), 64'(vecs[i].en));
            chk($sformatf("vec%0d wr_addr", i), 64'(wr_addr_o), 64'(vecs[i].addr));
            chk($sformatf("vec%0d wr_data", i), wr_data_o, vecs[i].data);
            chk($sformatf("vec%0d pending", i), 64'(pending_o), 64'(vecs[i].pend));
            chk($sformatf("vec%0d ready0", i), 64'(req0_ready_o), 64'(vecs[i].rdy0));
            chk($sformatf("vec%0d ready1", i), 64'(req1_ready_o), 64'(vecs[i].rdy1));
            chk($sformatf("vec%0d idle", i), 64'(idle_o), 64'(vecs[i].idle));
            tick();
        end

        // Single write latency and pending window
        drive(1'b1, 5'd20, 64'hBABEBEEFCAFEDEAD, 1'b0, 5'd0, 64'd0);
        tick();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("single k wr_en", 64'(wr_en_o), 64'd0);
        chk("single k pend20", 64'(pending_o[20]), 64'd1);
        tick();
        chk("single k+1 wr_en", 64'(wr_en_o), 64'd1);
        chk("single k+1 wr_addr", 64'(wr_addr_o), 64'd20);
        chk("single k+1 wr_data", wr_data_o, 64'hBABEBEEFCAFEDEAD);
        chk("single k+1 pend20", 64'(pending_o[20]), 64'd1);
        tick();
        chk("single k+2 wr_en", 64'(wr_en_o), 64'd0);
        chk("single k+2 pend20", 64'(pending_o[20]), 64'd0);
        chk("single k+2 idle", 64'(idle_o), 64'd1);

        // Contention from reset: requester 0 wins first, then alternation
        do_reset();
        exp_addr = '{5'd5, 5'd19, 5'd5, 5'd19};
        exp_data = '{64'h0500_0001, 64'h1900_0001, 64'h0500_0002, 64'h1900_0002};
        drive(1'b1, 5'd5, 64'h0500_0001, 1'b1, 5'd19, 64'h1900_0001);
        tick();
        drive(1'b1, 5'd5, 64'h0500_0002, 1'b1, 5'd19, 64'h1900_0002);
        tick();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("contend%0d wr_en", i), 64'(wr_en_o), 64'd1);
            chk($sformatf("contend%0d wr_addr", i), 64'(wr_addr_o), 64'(exp_addr[i]));
            chk($sformatf("contend%0d wr_data", i), wr_data_o, exp_data[i]);
            tick();
        end
        chk("contend drained wr_en", 64'(wr_en_o), 64'd0);
        chk("contend drained idle", 64'(idle_o), 64'd1);

        // Backpressure with both requesters saturating; scoreboard per requester
        do_reset();
        seen_full1 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c < 14) drive(1'b1, 5'd2, 64'h0200_0000 + 64'(c), 1'b1, 5'd17, 64'h1700_0000 + 64'(c));
            else        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
            if (req0_valid_i && req0_ready_o) q0.push_back(req0_data_i);
            if (req1_valid_i && req1_ready_o) q1.push_back(req1_data_i);
            tick();
            if (c == 1) chk("bp ready1 low after 2 accepts", 64'(req1_ready_o), 64'd0);
            if (c == 2) chk("bp ready1 back after pop", 64'(req1_ready_o), 64'd1);
            if (!req1_ready_o) seen_full1 = 1'b1;
            if (wr_en_o) begin
                if (wr_addr_o == 5'd2 && q0.size() > 0) begin
                    exp_d = q0.pop_front();
                    chk("bp req0 order", wr_data_o, exp_d);
                end else if (wr_addr_o == 5'd17 && q1.size() > 0) begin
                    exp_d = q1.pop_front();
                    chk("bp req1 order", wr_data_o, exp_d);
                end else begin
                    chk("bp unexpected write addr", 64'(wr_addr_o), 64'hFFFF);
                end
            end
        end
        chk("bp req1 saw full", 64'(seen_full1), 64'd1);
        chk("bp q0 drained", 64'(q0.size()), 64'd0);
        chk("bp q1 drained", 64'(q1.size()), 64'd0);
        chk("bp idle", 64'(idle_o), 64'd1);

        // Write to x0 is consumed without a write strobe
        drive(1'b1, 5'd0, 64'h1234567887654321, 1'b0, 5'd0, 64'd0);
        tick();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("x0 queued idle", 64'(idle_o), 64'd0);
        chk("x0 queued pend0", 64'(pending_o[0]), 64'd0);
        tick();
        chk("x0 pop wr_en", 64'(wr_en_o), 64'd0);
        chk("x0 pop pending", 64'(pending_o), 64'd0);
        chk("x0 pop idle", 64'(idle_o), 64'd1);
        tick();
        chk("x0 after wr_en", 64'(wr_en_o), 64'd0);

        // Reset asserted mid-stream discards everything
        drive(1'b1, 5'd9, 64'h9, 1'b1, 5'd11, 64'hB);
        tick();
        drive(1'b1, 5'd10, 64'hA, 1'b0, 5'd0, 64'd0);
        tick();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("midrst pre wr_en", 64'(wr_en_o), 64'd1);
        chk("midrst pre pending", 64'(pending_o), 64'h0000_0E00);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst wr_en", 64'(wr_en_o), 64'd0);
        chk("midrst idle", 64'(idle_o), 64'd1);
        chk("midrst pending", 64'(pending_o), 64'd0);
        chk("midrst ready0", 64'(req0_ready_o), 64'd1);
        tick();
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("postrst%0d wr_en", i), 64'(wr_en_o), 64'd0);
            chk($sformatf("postrst%0d idle", i), 64'(idle_o), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
